wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 alu_valid  input  1  ALU requester has a write-back pending.
REQ-006 alu_rd  input  ADDR_W  ALU destination register index.
REQ-007 alu_data  input  DATA_W  ALU write-back data.
REQ-008 alu_ready  output  1  ALU request accepted this cycle.
REQ-009 mem_valid  input  1  load unit has a write-back pending.
REQ-010 mem_rd  input  ADDR_W  load destination register index.
REQ-011 mem_data  input  DATA_W  load write-back data.
REQ-012 mem_ready  output  1  load request accepted this cycle.
REQ-013 wb_stall  input  1  register-file write port unavailable this cycle.
REQ-014 RegWrite  output  1  write enable to register file.
REQ-015 Rd  output  ADDR_W  write index to register file.
REQ-016 Write_data  output  DATA_W  write data to register file.
REQ-017 last_grant  output  1  requester of the most recent transfer: 0 = ALU, 1 = load.

Function
REQ-018 Transfer on a requester SHALL occur in any cycle where its valid and ready are both 1; ready SHALL be combinational from the valids, the priority pointer and wb_stall.
REQ-019 At most one ready SHALL be 1 per cycle; ready SHALL never be 1 while its valid is 0.
REQ-020 wb_stall=1 SHALL force both readys to 0.
REQ-021 If exactly one valid=1 and wb_stall=0, that requester SHALL be granted regardless of priority.
REQ-022 If both valids=1 and wb_stall=0, the requester selected by the priority pointer SHALL be granted (prio=0 ALU, prio=1 load).
REQ-023 After every transfer, prio SHALL point to the non-granted requester; with no transfer, prio SHALL hold.
REQ-024 Starvation bound: a requester continuously valid SHALL be granted within 2 non-stalled cycles.
REQ-025 A transfer in cycle t SHALL drive RegWrite=1 with Rd/Write_data = granted rd/data in cycle t+1 (latency 1, registered outputs).
REQ-026 A transfer with rd=0 SHALL complete the handshake, update prio and last_grant, but drive RegWrite=0 in t+1 (x0 never written).
REQ-027 With no transfer in cycle t, RegWrite SHALL be 0 in t+1; Rd and Write_data SHALL hold their previous values.
REQ-028 Requesters SHALL hold rd/data stable while valid=1 and ready=0; valid SHALL not be withdrawn before transfer (bench assertion).
REQ-029 Both requesters targeting the same rd SHALL be written in grant order, the later write taking effect last.

Reset
REQ-030 reset=1 SHALL immediately set RegWrite=0, Rd=0, Write_data=0, last_grant=0, prio=0, independent of clk.
REQ-031 While reset=1, alu_ready and mem_ready SHALL be 0; a transfer coinciding with reset assertion SHALL be discarded.
REQ-032 First transfer after reset release with both valid SHALL grant ALU.

Structure
REQ-033 DATA_W, ADDR_W and the requester ID encoding (ALU=0, LOAD=1) SHALL reside in a shared package used by the datapath.
REQ-034 Grant logic and priority pointer SHALL be one sub-module, rr_arb2 (2-input round-robin); output register stage stays in the top.

Verification
REQ-035 Reset, then alu_valid=1 rd=5 data=0x0000000A only -> alu_ready=1 same cycle; next cycle RegWrite=1, Rd=5, Write_data=0x0000000A, last_grant=0.
REQ-036 Both valid for 4 cycles (alu rd=1 / mem rd=2) -> grants ALU, load, ALU, load; RegWrite=1 each following cycle with matching Rd.
REQ-037 mem_valid=1 rd=0 data=0xFFFFFFFF -> mem_ready=1; next cycle RegWrite=0, last_grant=1, prio points to ALU.
REQ-038 Both valid with wb_stall=1 for 3 cycles -> both readys 0, RegWrite 0, prio unchanged; stall released -> priority requester granted first.
REQ-039 Assert reset between transfer and write-back cycle -> RegWrite=0 immediately, all outputs 0; after release, both valid -> ALU granted.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and requester identities for the write-back port arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package wb_port_arbiter_pkg;

    // Default register-file geometry: 32 registers of 32 bits.
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;

    // Number of requesters competing for the single write port.
    localparam int NUM_REQ = 2;

    // Requester identity. The encoding is also the bit index into the
    // valid/grant vectors and the value reported on last_grant.
    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_t;

    // The requester that did not win; the priority pointer moves here
    // after every transfer.
    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_ALU) ? REQ_LOAD : REQ_ALU;
    endfunction

endpackage : wb_port_arbiter_pkg

// File: rtl/wb_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a one-bit priority pointer.
// Latency: grant is combinational from valids, pointer and stall; pointer updates on the transfer edge.
// Backpressure: i_stall (or reset) withholds every grant; the pointer then holds.
//
// Ports:
//   i_clk, i_reset  clock and asynchronous active-high reset
//   i_vld           per-requester valid, indexed by req_id_t
//   i_stall         shared resource unavailable this cycle
//   o_gnt           per-requester grant (doubles as ready), at most one hot
//   o_gnt_id        identity of the granted requester (meaningful when o_xfer)
//   o_xfer          a transfer happens this cycle
module rr_arb2
    import wb_port_arbiter_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_vld,
    input  logic               i_stall,
    output logic [NUM_REQ-1:0] o_gnt,
    output req_id_t            o_gnt_id,
    output logic               o_xfer
);

    req_id_t            r_prio;
    logic [NUM_REQ-1:0] w_gnt;
    req_id_t            w_gnt_id;
    logic               w_xfer;

    // Grant selection. A lone requester always wins; the pointer only
    // breaks ties. Reset gates the grant combinationally so nothing can
    // be handed out while the pipeline is being cleared.
    always_comb begin
        w_gnt = '0;
        if (!i_reset && !i_stall) begin
            case (i_vld)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_prio == REQ_ALU) ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    // Grant is one-hot or zero, so the load bit alone names the winner.
    assign w_gnt_id = w_gnt[REQ_LOAD] ? REQ_LOAD : REQ_ALU;
    assign w_xfer   = |w_gnt;

    // Ready is only ever raised alongside valid, so a grant is a transfer.
    // After each transfer the loser gets priority, which bounds waiting
    // to one lost tie.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prio <= REQ_ALU;
        end else if (w_xfer) begin
            r_prio <= other_req(w_gnt_id);
        end
    end

    assign o_gnt    = w_gnt;
    assign o_gnt_id = w_gnt_id;
    assign o_xfer   = w_xfer;

endmodule : rr_arb2

// File: rtl/wb_port_arbiter.sv
// Arbitrates ALU and load write-backs onto a single register-file write port.
// Latency: one cycle from handshake to RegWrite/Rd/Write_data (registered outputs).
// Backpressure: wb_stall drops both readys; requesters hold rd/data until accepted.
//
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   alu_valid/alu_rd/alu_data       ALU write-back request, alu_ready accepts it
//   mem_valid/mem_rd/mem_data       load write-back request, mem_ready accepts it
//   wb_stall                        write port unavailable this cycle
//   RegWrite/Rd/Write_data          register-file write port
//   last_grant                      requester of the most recent transfer (0 ALU, 1 load)
module wb_port_arbiter
    import wb_port_arbiter_pkg::req_id_t;
    import wb_port_arbiter_pkg::REQ_ALU;
    import wb_port_arbiter_pkg::REQ_LOAD;
    import wb_port_arbiter_pkg::NUM_REQ;
#(
    parameter int DATA_W = wb_port_arbiter_pkg::DATA_W,
    parameter int ADDR_W = wb_port_arbiter_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,

    input  logic              wb_stall,

    output logic              RegWrite,
    output logic [ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0] Write_data,
    output logic              last_grant
);

    logic [NUM_REQ-1:0] w_vld;
    logic [NUM_REQ-1:0] w_gnt;
    req_id_t            w_gnt_id;
    logic               w_xfer;
    logic [ADDR_W-1:0]  w_sel_rd;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_sel_is_x0;

    logic               r_reg_write;
    logic [ADDR_W-1:0]  r_rd;
    logic [DATA_W-1:0]  r_wdata;
    req_id_t            r_last_grant;

    always_comb begin
        w_vld           = '0;
        w_vld[REQ_ALU]  = alu_valid;
        w_vld[REQ_LOAD] = mem_valid;
    end

    rr_arb2 u_arb (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_vld    (w_vld),
        .i_stall  (wb_stall),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id),
        .o_xfer   (w_xfer)
    );

    assign alu_ready = w_gnt[REQ_ALU];
    assign mem_ready = w_gnt[REQ_LOAD];

    // Steer the winner's payload toward the write port.
    assign w_sel_rd    = (w_gnt_id == REQ_LOAD) ? mem_rd   : alu_rd;
    assign w_sel_data  = (w_gnt_id == REQ_LOAD) ? mem_data : alu_data;

    // x0 is hard-wired zero: the handshake still completes and arbitration
    // state advances, but no write is issued.
    assign w_sel_is_x0 = (w_sel_rd == '0);

    // Output stage. Rd/Write_data only move on a transfer so the port
    // holds its last address/data when idle; RegWrite is a one-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_wdata      <= '0;
            r_last_grant <= REQ_ALU;
        end else begin
            r_reg_write <= w_xfer && !w_sel_is_x0;
            if (w_xfer) begin
                r_rd         <= w_sel_rd;
                r_wdata      <= w_sel_data;
                r_last_grant <= w_gnt_id;
            end
        end
    end

    assign RegWrite   = r_reg_write;
    assign Rd         = r_rd;
    assign Write_data = r_wdata;
    assign last_grant = r_last_grant;

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a randomized run
// against a behavioural model (tie-break pointer, one-cycle write-back, x0 suppression).
// Inputs change on the falling edge; readys are sampled 1 ns later, registered outputs on the next falling edge.
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, mem_valid, wb_stall;
    logic [AW-1:0] alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          RegWrite, last_grant;
    logic [AW-1:0] Rd;
    logic [DW-1:0] Write_data;

    integer errors = 0;
    integer checks = 0;

    // Reference model state
    int            m_prio;      // 0: ALU wins a tie, 1: load wins a tie
    logic          m_we;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    logic          m_last;
    bit            m_known;     // Rd/Write_data defined by the model

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .wb_stall   (wb_stall),
        .RegWrite   (RegWrite),
        .Rd         (Rd),
        .Write_data (Write_data),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // Expected {mem_ready, alu_ready} from the arbitration rules.
    function automatic logic [1:0] exp_grant();
        if (reset || wb_stall) return 2'b00;
        if (alu_valid && mem_valid) return (m_prio == 0) ? 2'b01 : 2'b10;
        return {mem_valid, alu_valid};
    endfunction

    task automatic model_reset();
        m_prio  = 0;
        m_we    = 1'b0;
        m_rd    = '0;
        m_data  = '0;
        m_last  = 1'b0;
        m_known = 1'b1;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                         input logic st);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        wb_stall  = st;
    endtask

    // One clock: predict the grant, take the edge, update the model, return at the falling edge.
    task automatic advance(output logic [1:0] g);
        g = exp_grant();
        @(posedge clk);
        if (g != 2'b00) begin
            m_last = g[1];
            m_prio = g[1] ? 0 : 1;
            if (g[1]) begin
                m_rd = mem_rd; m_data = mem_data;
            end else begin
                m_rd = alu_rd; m_data = alu_data;
            end
            m_we    = (m_rd != '0);
            m_known = m_we;
        end else begin
            m_we = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b0);
        model_reset();
        #2;
        checks++;
        if ({mem_ready, alu_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got=%b want=00", {mem_ready, alu_ready});
        end
        checks++;
        if ({RegWrite, Rd, Write_data, last_grant} !== '0) begin
            errors++; $display("FAIL reset_outputs got we=%b rd=%0d data=%h last=%b want all 0",
                               RegWrite, Rd, Write_data, last_grant);
        end
        @(posedge clk); #1;
        checks++;
        if ({RegWrite, Rd, Write_data, last_grant} !== '0) begin
            errors++; $display("FAIL reset_held got we=%b rd=%0d data=%h last=%b want all 0",
                               RegWrite, Rd, Write_data, last_grant);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_single_alu();
        logic [1:0] g;
        drive(1'b1, 5'd5, 32'h0000000A, 1'b0, '0, '0, 1'b0);
        #1;
        checks++;
        if ({mem_ready, alu_ready} !== 2'b01) begin
            errors++; $display("FAIL single_alu_ready got=%b want=01", {mem_ready, alu_ready});
        end
        advance(g);
        checks++;
        if ({RegWrite, Rd, Write_data, last_grant} !== {1'b1, 5'd5, 32'h0000000A, 1'b0}) begin
            errors++; $display("FAIL single_alu_wb got we=%b rd=%0d data=%h last=%b want 1/5/0000000a/0",
                               RegWrite, Rd, Write_data, last_grant);
        end
    endtask

    task automatic test_rd_zero();
        logic [1:0] g;
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        #1;
        checks++;
        if ({mem_ready, alu_ready} !== 2'b10) begin
            errors++; $display("FAIL rd0_ready got=%b want=10", {mem_ready, alu_ready});
        end
        advance(g);
        checks++;
        if ({RegWrite, last_grant} !== 2'b01) begin
            errors++; $display("FAIL rd0_wb got we=%b last=%b want we=0 last=1", RegWrite, last_grant);
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        advance(g);
        checks++;
        if ({RegWrite, last_grant} !== 2'b01) begin
            errors++; $display("FAIL rd0_idle got we=%b last=%b want we=0 last=1", RegWrite, last_grant);
        end
    endtask

    // Priority points at ALU here (the last transfer was a load).
    task automatic test_alternate();
        logic [1:0] g;
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({mem_ready, alu_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL alt_ready[%0d] got=%b want=%b", i, {mem_ready, alu_ready},
                                   (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            advance(g);
            checks++;
            if ({RegWrite, Rd, last_grant} !== {1'b1, (i % 2 == 0) ? 5'd1 : 5'd2, (i % 2 == 1) ? 1'b1 : 1'b0}) begin
                errors++; $display("FAIL alt_wb[%0d] got we=%b rd=%0d last=%b want we=1 rd=%0d last=%0d",
                                   i, RegWrite, Rd, last_grant, (i % 2 == 0) ? 1 : 2, i % 2);
            end
        end
    endtask

    task automatic test_stall();
        logic [1:0] g;
        drive(1'b1, 5'd1, 32'h33, 1'b1, 5'd2, 32'h44, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({mem_ready, alu_ready} !== 2'b00) begin
                errors++; $display("FAIL stall_ready[%0d] got=%b want=00", i, {mem_ready, alu_ready});
            end
            advance(g);
            checks++;
            if ({RegWrite, Rd, Write_data, last_grant} !== {1'b0, 5'd2, 32'h22, 1'b1}) begin
                errors++; $display("FAIL stall_hold[%0d] got we=%b rd=%0d data=%h last=%b want 0/2/00000022/1",
                                   i, RegWrite, Rd, Write_data, last_grant);
            end
        end
        wb_stall = 1'b0;
        #1;
        checks++;
        if ({mem_ready, alu_ready} !== 2'b01) begin
            errors++; $display("FAIL stall_release_ready got=%b want=01", {mem_ready, alu_ready});
        end
        advance(g);
        checks++;
        if ({RegWrite, Rd, Write_data, last_grant} !== {1'b1, 5'd1, 32'h33, 1'b0}) begin
            errors++; $display("FAIL stall_release_wb got we=%b rd=%0d data=%h last=%b want 1/1/00000033/0",
                               RegWrite, Rd, Write_data, last_grant);
        end
    endtask

    // Priority points at load here, so the in-flight transfer is the load's.
    task automatic test_reset_midflight();
        logic [1:0] g;
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99, 1'b0);
        #1;
        checks++;
        if ({mem_ready, alu_ready} !== 2'b10) begin
            errors++; $display("FAIL midrst_ready got=%b want=10", {mem_ready, alu_ready});
        end
        @(posedge clk); #1;
        checks++;
        if ({RegWrite, Rd} !== {1'b1, 5'd9}) begin
            errors++; $display("FAIL midrst_pre got we=%b rd=%0d want we=1 rd=9", RegWrite, Rd);
        end
        #1 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({RegWrite, Rd, Write_data, last_grant, mem_ready, alu_ready} !== '0) begin
            errors++; $display("FAIL midrst_clear got we=%b rd=%0d data=%h last=%b rdy=%b want all 0",
                               RegWrite, Rd, Write_data, last_grant, {mem_ready, alu_ready});
        end
        @(posedge clk); #1;
        checks++;
        if ({RegWrite, Rd, Write_data, last_grant} !== '0) begin
            errors++; $display("FAIL midrst_during got we=%b rd=%0d data=%h last=%b want all 0",
                               RegWrite, Rd, Write_data, last_grant);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_ready, alu_ready} !== 2'b01) begin
            errors++; $display("FAIL midrst_first_ready got=%b want=01", {mem_ready, alu_ready});
        end
        advance(g);
        checks++;
        if ({RegWrite, Rd, Write_data, last_grant} !== {1'b1, 5'd7, 32'h77, 1'b0}) begin
            errors++; $display("FAIL midrst_first_wb got we=%b rd=%0d data=%h last=%b want 1/7/00000077/0",
                               RegWrite, Rd, Write_data, last_grant);
        end
    endtask

    // Random traffic: requesters hold rd/data until accepted; small rd range
    // makes x0 and same-register collisions frequent.
    task automatic test_random();
        logic [1:0]    g, ge;
        bit            pa, pm;
        logic [AW-1:0] ra, rm;
        logic [DW-1:0] da, dm;
        logic          st;
        int            wa, wm;
        pa = 0; pm = 0; wa = 0; wm = 0;
        ra = '0; rm = '0; da = '0; dm = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && $urandom_range(0, 9) < 6) begin
                pa = 1; ra = AW'($urandom_range(0, 3)); da = $urandom;
            end
            if (!pm && $urandom_range(0, 9) < 6) begin
                pm = 1; rm = AW'($urandom_range(0, 3)); dm = $urandom;
            end
            st = ($urandom_range(0, 3) == 0);
            drive(pa, ra, da, pm, rm, dm, st);
            #1;
            ge = exp_grant();
            checks++;
            if ({mem_ready, alu_ready} !== ge) begin
                errors++; $display("FAIL rand_ready[%0d] got=%b want=%b", c, {mem_ready, alu_ready}, ge);
            end
            advance(g);
            checks++;
            if ({RegWrite, last_grant} !== {m_we, m_last}) begin
                errors++; $display("FAIL rand_ctrl[%0d] got we=%b last=%b want we=%b last=%b",
                                   c, RegWrite, last_grant, m_we, m_last);
            end
            if (m_known) begin
                checks++;
                if ({Rd, Write_data} !== {m_rd, m_data}) begin
                    errors++; $display("FAIL rand_port[%0d] got rd=%0d data=%h want rd=%0d data=%h",
                                       c, Rd, Write_data, m_rd, m_data);
                end
            end
            if (pa && !g[0] && !st) begin
                wa++;
                checks++;
                if (wa > 1) begin
                    errors++; $display("FAIL rand_starve_alu[%0d] got wait=%0d want<=1", c, wa);
                end
            end
            if (pm && !g[1] && !st) begin
                wm++;
                checks++;
                if (wm > 1) begin
                    errors++; $display("FAIL rand_starve_mem[%0d] got wait=%0d want<=1", c, wm);
                end
            end
            if (g[0]) begin pa = 0; wa = 0; end
            if (g[1]) begin pm = 0; wm = 0; end
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_rd_zero();
        test_alternate();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wb_port_arbiter
